pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage pipeline (IF/ID/EX/DM/WB).
//  Mirrors in-flight destinations (EX/DM/WB scoreboard) and sets forwarding selects for ID/EX.
//  Also drives load-use stalls, redirect flushes and the syscall-halt drain sequence.
//  Sits beside the pipeline registers; replaces hard-wired en(1)/clr of IF/ID and ID/EX.
// PARAMETERS
//  CNT_W      16  width of saturating stall/flush event counters
//  DRAIN_CYC  2   cycles from halt leaving EX until it retires from WB
// PORTS
//  clk          in   1      clock, posedge
//  rst_n        in   1      reset, asynchronous, active-low
//  en           in   1      global enable; 0 freezes all state and counters
//  id_req_a     in   5      resolved RF read index A of instr in ID
//  id_req_b     in   5      resolved RF read index B of instr in ID
//  id_use_a     in   1      instr in ID consumes A
//  id_use_b     in   1      instr in ID consumes B
//  id_w_en      in   1      instr in ID writes RF
//  id_req_w     in   5      destination index of instr in ID
//  id_is_load   in   1      instr in ID takes WB data from data memory
//  ex_redirect  in   1      jumped|branched from WTG in EX
//  ex_halt      in   1      syscall halt asserted in EX
//  pc_stall     out  1      hold PC
//  if_id_stall  out  1      hold IF/ID register
//  if_id_clr    out  1      clear IF/ID at next edge
//  id_ex_clr    out  1      load bubble into ID/EX at next edge
//  fwd_a        out  2      EX operand-A select, registered via ID/EX: 0 OLD, 1 EX(ex_dm), 2 DM(dm_wb)
//  fwd_b        out  2      same for operand B
//  id_byp_a     out  1      ID/EX captures regfile_data_w_wb instead of RF port A
//  id_byp_b     out  1      same for port B
//  halted       out  1      pipeline drained after syscall halt
//  stall_cnt    out  CNT_W  load-use stall cycles, saturating
//  flush_cnt    out  CNT_W  redirect flush events, saturating
// BEHAVIOUR
//  Scoreboard: slots EX/DM/WB of {vld,w_en,dst,ld}; advance when en&&state!=HALTED:
//   WB<=DM, DM<=EX, EX<=ID (or vld=0 when id_ex_clr). dst==0 never matches.
//  match(S,r): S.vld && S.w_en && S.dst==r && r!=0.
//  Load-use: luse = (id_use_a&&match(EX,id_req_a)&&EX.ld) | same for b.
//   => pc_stall=if_id_stall=id_ex_clr=1 one cycle; next cycle load is in DM, fwd=2.
//  fwd_x (x=a,b, only if id_use_x): match(EX)&&!EX.ld -> 1; else match(DM) -> 2; else 0.
//  id_byp_x = id_use_x && match(WB) && no EX/DM match (youngest wins).
//  Redirect beats load-use: ex_redirect -> if_id_clr=id_ex_clr=1, no stall, flush_cnt++.
//  FSM RUN -> DRAIN on ex_halt (ex_halt ignored if ex_redirect same cycle? no: halt wins,
//   syscall never branches). DRAIN: pc_stall=if_id_clr=id_ex_clr=1, counter from DRAIN_CYC-1
//   down to 0 -> HALTED. HALTED: pc_stall=if_id_stall=id_ex_clr=1, halted=1, until reset.
//  en=0: outputs recomputed combinationally from held state; no state/counter updates.
//  Counters saturate at all-ones. stall_cnt counts cycles luse && RUN && en.
//  Reset (async): state RUN, scoreboard vld=0, counters 0; outputs all 0, fwd=0.
//  Reset mid-DRAIN/HALTED returns to RUN immediately.
// STRUCTURE
//  Core.vh: FWD_OLD/FWD_EX/FWD_DM (width MUX_EX_REDIR_DATA*_BIT), HZ_ST_RUN/DRAIN/HALTED.
//  Sub-module hz_scoreboard: 3-slot shift + match logic; FSM/counters stay in top.
// TESTING
//  add $1; add $2,$1,$1 -> fwd_a=fwd_b=1, no stall, stall_cnt=0.
//  lw $3; add $4,$3,$0 -> 1 stall cycle, bubble, then fwd_a=2; stall_cnt=1.
//  add $5; nop; nop; sub $6,$5 -> id_byp_a=1 when add in WB, fwd_a=0.
//  beq taken with lw-use pending in ID -> clr both, no stall, flush_cnt=1.
//  syscall halt in EX -> DRAIN 2 cycles, halted=1 on 3rd, PC held; rst_n low -> RUN, cnts 0.
//  writes to $0 + en=0 mid-stall -> never forwarded; state frozen while en=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller:
// forwarding-select codes, FSM states, scoreboard slot layout and match rules.
package pipe_hazard_ctrl_pkg;

  localparam int FWD_W = 2;

  localparam logic [FWD_W-1:0] FWD_OLD = 2'd0;
  localparam logic [FWD_W-1:0] FWD_EX  = 2'd1;
  localparam logic [FWD_W-1:0] FWD_DM  = 2'd2;

  typedef enum logic [1:0] {
    HZ_ST_RUN    = 2'd0,
    HZ_ST_DRAIN  = 2'd1,
    HZ_ST_HALTED = 2'd2
  } hz_state_e;

  // One in-flight instruction as seen by the hazard logic
  typedef struct packed {
    logic       vld;
    logic       w_en;
    logic [4:0] dst;
    logic       ld;
  } sb_slot_t;

  localparam sb_slot_t SLOT_EMPTY = '0;

  // Register 0 is hardwired, so a write to it is never a producer
  function automatic logic slot_match(sb_slot_t s, logic [4:0] r);
    return s.vld && s.w_en && (s.dst == r) && (r != 5'd0);
  endfunction

  // Operand select for the instruction leaving ID; a load in EX cannot forward yet
  function automatic logic [FWD_W-1:0] fwd_sel(sb_slot_t ex, sb_slot_t dm,
                                               logic rd_used, logic [4:0] r);
    logic [FWD_W-1:0] sel;
    sel = FWD_OLD;
    if (rd_used) begin
      if (slot_match(ex, r) && !ex.ld) sel = FWD_EX;
      else if (slot_match(dm, r))      sel = FWD_DM;
    end
    return sel;
  endfunction

  // WB value is only used when no younger producer of the same register exists
  function automatic logic wb_bypass(sb_slot_t ex, sb_slot_t dm, sb_slot_t wb,
                                     logic rd_used, logic [4:0] r);
    return rd_used && slot_match(wb, r) && !slot_match(ex, r) && !slot_match(dm, r);
  endfunction

  function automatic logic load_use(sb_slot_t ex, logic rd_used, logic [4:0] r);
    return rd_used && slot_match(ex, r) && ex.ld;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of ID/EX-side requests and hazard-control responses.
// The pipeline drives through 'master'; the controller sits on 'slave'.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic [4:0]       id_req_a;
  logic [4:0]       id_req_b;
  logic             id_use_a;
  logic             id_use_b;
  logic             id_w_en;
  logic [4:0]       id_req_w;
  logic             id_is_load;
  logic             ex_redirect;
  logic             ex_halt;

  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_clr;
  logic             id_ex_clr;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             id_byp_a;
  logic             id_byp_b;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output en, id_req_a, id_req_b, id_use_a, id_use_b, id_w_en, id_req_w,
           id_is_load, ex_redirect, ex_halt,
    input  pc_stall, if_id_stall, if_id_clr, id_ex_clr, fwd_a, fwd_b,
           id_byp_a, id_byp_b, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  en, id_req_a, id_req_b, id_use_a, id_use_b, id_w_en, id_req_w,
           id_is_load, ex_redirect, ex_halt,
    output pc_stall, if_id_stall, if_id_clr, id_ex_clr, fwd_a, fwd_b,
           id_byp_a, id_byp_b, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Hazard scoreboard: shadows the destinations held in EX, DM and WB and
// derives load-use, forwarding-select and WB-bypass decisions for ID.
module pipe_hazard_ctrl_scoreboard
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             bubble_i,
  input  logic             id_w_en_i,
  input  logic [4:0]       id_req_w_i,
  input  logic             id_is_load_i,
  input  logic [4:0]       id_req_a_i,
  input  logic [4:0]       id_req_b_i,
  input  logic             id_use_a_i,
  input  logic             id_use_b_i,
  output logic             luse_o,
  output logic [FWD_W-1:0] fwd_a_o,
  output logic [FWD_W-1:0] fwd_b_o,
  output logic             byp_a_o,
  output logic             byp_b_o
);

  sb_slot_t ex_q, dm_q, wb_q;
  sb_slot_t ex_d;

  // What enters EX: the ID instruction, or an empty slot when a bubble is injected
  always_comb begin
    ex_d = SLOT_EMPTY;
    if (!bubble_i) begin
      ex_d.vld  = 1'b1;
      ex_d.w_en = id_w_en_i;
      ex_d.dst  = id_req_w_i;
      ex_d.ld   = id_is_load_i;
    end
  end

  // Shift the shadow pipeline in lock-step with the real stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= SLOT_EMPTY;
      dm_q <= SLOT_EMPTY;
      wb_q <= SLOT_EMPTY;
    end else if (adv_i) begin
      wb_q <= dm_q;
      dm_q <= ex_q;
      ex_q <= ex_d;
    end
  end

  assign luse_o  = load_use(ex_q, id_use_a_i, id_req_a_i) |
                   load_use(ex_q, id_use_b_i, id_req_b_i);
  assign fwd_a_o = fwd_sel(ex_q, dm_q, id_use_a_i, id_req_a_i);
  assign fwd_b_o = fwd_sel(ex_q, dm_q, id_use_b_i, id_req_b_i);
  assign byp_a_o = wb_bypass(ex_q, dm_q, wb_q, id_use_a_i, id_req_a_i);
  assign byp_b_o = wb_bypass(ex_q, dm_q, wb_q, id_use_b_i, id_req_b_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline. Owns the
// run/drain/halted sequence and the stall/flush event counters; the
// in-flight register tracking lives in the scoreboard sub-module.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 2
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int               DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0]    DRAIN_INIT = DW'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  hz_state_e        state_q;
  logic [DW-1:0]    drain_q;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic             luse;
  logic             adv;
  logic             pc_stall, if_id_stall, if_id_clr, id_ex_clr;
  logic [FWD_W-1:0] fwd_a, fwd_b;
  logic             byp_a, byp_b;

  // Frozen pipeline (en low or halted) must not shift the scoreboard
  assign adv = hz.en && (state_q != HZ_ST_HALTED);

  pipe_hazard_ctrl_scoreboard u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .adv_i        (adv),
    .bubble_i     (id_ex_clr),
    .id_w_en_i    (hz.id_w_en),
    .id_req_w_i   (hz.id_req_w),
    .id_is_load_i (hz.id_is_load),
    .id_req_a_i   (hz.id_req_a),
    .id_req_b_i   (hz.id_req_b),
    .id_use_a_i   (hz.id_use_a),
    .id_use_b_i   (hz.id_use_b),
    .luse_o       (luse),
    .fwd_a_o      (fwd_a),
    .fwd_b_o      (fwd_b),
    .byp_a_o      (byp_a),
    .byp_b_o      (byp_b)
  );

  assign stall_d = (stall_q == CNT_MAX) ? stall_q : stall_q + CNT_W'(1);
  assign flush_d = (flush_q == CNT_MAX) ? flush_q : flush_q + CNT_W'(1);

  // Pipeline-register controls; priority in RUN is halt, then redirect, then load-use
  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_clr   = 1'b0;
    id_ex_clr   = 1'b0;
    case (state_q)
      HZ_ST_RUN: begin
        if (hz.ex_halt) begin
          pc_stall  = 1'b1;
          if_id_clr = 1'b1;
          id_ex_clr = 1'b1;
        end else if (hz.ex_redirect) begin
          if_id_clr = 1'b1;
          id_ex_clr = 1'b1;
        end else if (luse) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_clr   = 1'b1;
        end
      end
      HZ_ST_DRAIN: begin
        pc_stall  = 1'b1;
        if_id_clr = 1'b1;
        id_ex_clr = 1'b1;
      end
      HZ_ST_HALTED: begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_clr   = 1'b1;
      end
      default: begin
        pc_stall = 1'b0;
      end
    endcase
  end

  // Sequencing FSM and event counters; stall_cnt counts only cycles that actually stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HZ_ST_RUN;
      drain_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else if (hz.en) begin
      case (state_q)
        HZ_ST_RUN: begin
          if (hz.ex_halt) begin
            state_q <= HZ_ST_DRAIN;
            drain_q <= DRAIN_INIT;
          end else if (hz.ex_redirect) begin
            flush_q <= flush_d;
          end else if (luse) begin
            stall_q <= stall_d;
          end
        end
        HZ_ST_DRAIN: begin
          if (drain_q == '0) state_q <= HZ_ST_HALTED;
          else               drain_q <= drain_q - DW'(1);
        end
        HZ_ST_HALTED: state_q <= HZ_ST_HALTED;
        default:      state_q <= HZ_ST_RUN;
      endcase
    end
  end

  assign hz.pc_stall    = pc_stall;
  assign hz.if_id_stall = if_id_stall;
  assign hz.if_id_clr   = if_id_clr;
  assign hz.id_ex_clr   = id_ex_clr;
  assign hz.fwd_a       = fwd_a;
  assign hz.fwd_b       = fwd_b;
  assign hz.id_byp_a    = byp_a;
  assign hz.id_byp_b    = byp_b;
  assign hz.halted      = (state_q == HZ_ST_HALTED);
  assign hz.stall_cnt   = stall_q;
  assign hz.flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios
// followed by random traffic, all compared against an instruction-level model.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W       = 16;
  localparam int DRAIN_CYC   = 2;
  localparam int CNT_SAT     = (1 << CNT_W) - 1;
  localparam int RAND_CYCLES = 800;

  typedef struct {
    bit valid;
    bit writes;
    int dst;
    bit isLoad;
  } InstrRec;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  // Free-running clock, period 10
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  // flight[0] = instruction in EX, [1] = DM, [2] = WB
  InstrRec flight [3];
  int sinceHalt;
  int stallCount;
  int flushCount;
  int total;
  int bad;
  int haltedCycles;

  bit expPc, expIfStall, expIfClr, expIdClr, expHalted, expLuse, expBypA, expBypB;
  int expFwdA, expFwdB;

  function automatic bit writesReg(int stage, int r);
    return (r != 0) && flight[stage].valid && flight[stage].writes && (flight[stage].dst == r);
  endfunction

  function automatic int youngestProducer(int r);
    for (int i = 0; i < 3; i++) if (writesReg(i, r)) return i;
    return -1;
  endfunction

  function automatic int fwdFor(bit used, int r);
    if (!used) return 0;
    if (writesReg(0, r) && !flight[0].isLoad) return 1;
    if (writesReg(1, r)) return 2;
    return 0;
  endfunction

  function automatic bit loadUse(bit used, int r);
    return used && (youngestProducer(r) == 0) && flight[0].isLoad;
  endfunction

  function automatic void computeExpect();
    int ra, rb;
    ra = int'(hz.id_req_a);
    rb = int'(hz.id_req_b);
    expLuse    = loadUse(hz.id_use_a, ra) || loadUse(hz.id_use_b, rb);
    expFwdA    = fwdFor(hz.id_use_a, ra);
    expFwdB    = fwdFor(hz.id_use_b, rb);
    expBypA    = hz.id_use_a && (youngestProducer(ra) == 2);
    expBypB    = hz.id_use_b && (youngestProducer(rb) == 2);
    expPc      = 1'b0;
    expIfStall = 1'b0;
    expIfClr   = 1'b0;
    expIdClr   = 1'b0;
    expHalted  = 1'b0;
    if (sinceHalt > DRAIN_CYC) begin
      expPc = 1'b1; expIfStall = 1'b1; expIdClr = 1'b1; expHalted = 1'b1;
    end else if (sinceHalt >= 1 || hz.ex_halt) begin
      expPc = 1'b1; expIfClr = 1'b1; expIdClr = 1'b1;
    end else if (hz.ex_redirect) begin
      expIfClr = 1'b1; expIdClr = 1'b1;
    end else if (expLuse) begin
      expPc = 1'b1; expIfStall = 1'b1; expIdClr = 1'b1;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    computeExpect();
    check("pc_stall",    32'(hz.pc_stall),    32'(expPc));
    check("if_id_stall", 32'(hz.if_id_stall), 32'(expIfStall));
    check("if_id_clr",   32'(hz.if_id_clr),   32'(expIfClr));
    check("id_ex_clr",   32'(hz.id_ex_clr),   32'(expIdClr));
    check("fwd_a",       32'(hz.fwd_a),       32'(expFwdA));
    check("fwd_b",       32'(hz.fwd_b),       32'(expFwdB));
    check("id_byp_a",    32'(hz.id_byp_a),    32'(expBypA));
    check("id_byp_b",    32'(hz.id_byp_b),    32'(expBypB));
    check("halted",      32'(hz.halted),      32'(expHalted));
    check("stall_cnt",   32'(hz.stall_cnt),   32'(stallCount));
    check("flush_cnt",   32'(hz.flush_cnt),   32'(flushCount));
  endtask

  // Advance the model by one clock using the inputs currently driven
  task automatic modelStep();
    if (!hz.en) return;
    if (sinceHalt == 0) begin
      if (hz.ex_halt) sinceHalt = 1;
      else if (hz.ex_redirect) begin
        if (flushCount < CNT_SAT) flushCount++;
      end else if (expLuse) begin
        if (stallCount < CNT_SAT) stallCount++;
      end
    end else if (sinceHalt <= DRAIN_CYC) begin
      sinceHalt++;
    end else begin
      return;
    end
    flight[2] = flight[1];
    flight[1] = flight[0];
    flight[0].valid  = !expIdClr;
    flight[0].writes = !expIdClr && hz.id_w_en;
    flight[0].dst    = expIdClr ? 0 : int'(hz.id_req_w);
    flight[0].isLoad = !expIdClr && hz.id_is_load;
  endtask

  task automatic clearModel();
    for (int i = 0; i < 3; i++) begin
      flight[i].valid = 1'b0; flight[i].writes = 1'b0;
      flight[i].dst = 0;      flight[i].isLoad = 1'b0;
    end
    sinceHalt  = 0;
    stallCount = 0;
    flushCount = 0;
  endtask

  task automatic driveInputs(input bit en, input bit ua, input int ra, input bit ub, input int rb,
                             input bit w, input int rw, input bit ld, input bit redir, input bit halt);
    hz.en          = en;
    hz.id_use_a    = ua;
    hz.id_req_a    = 5'(ra);
    hz.id_use_b    = ub;
    hz.id_req_b    = 5'(rb);
    hz.id_w_en     = w;
    hz.id_req_w    = 5'(rw);
    hz.id_is_load  = ld;
    hz.ex_redirect = redir;
    hz.ex_halt     = halt;
  endtask

  // One cycle: drive on the falling edge, check, then account for the rising edge
  task automatic applyStimulus(input bit en, input bit ua, input int ra, input bit ub, input int rb,
                               input bit w, input int rw, input bit ld, input bit redir, input bit halt);
    @(negedge clk);
    driveInputs(en, ua, ra, ub, rb, w, rw, ld, redir, halt);
    #1;
    checkOutput();
    modelStep();
  endtask

  task automatic nop();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    driveInputs(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    clearModel();
    #1;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    haltedCycles = 0;
    clearModel();
    driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("[TB] start");
    resetDut();

    // add $1 ; add $2,$1,$1 -> both operands from EX
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 1, 1, 2, 0, 0, 0);
    check("fwd_ex_a", 32'(hz.fwd_a), 32'd1);
    nop();

    // lw $3 ; add $4,$3,$0 -> one stall, then DM forward
    applyStimulus(1, 0, 0, 0, 0, 1, 3, 1, 0, 0);
    applyStimulus(1, 1, 3, 1, 0, 1, 4, 0, 0, 0);
    check("luse_stall", 32'(hz.pc_stall), 32'd1);
    applyStimulus(1, 1, 3, 1, 0, 1, 4, 0, 0, 0);
    check("fwd_dm_a", 32'(hz.fwd_a), 32'd2);

    // add $5 ; nop ; nop ; sub $6,$5 -> WB bypass
    applyStimulus(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    nop();
    nop();
    applyStimulus(1, 1, 5, 0, 0, 1, 6, 0, 0, 0);
    check("wb_byp_a", 32'(hz.id_byp_a), 32'd1);

    // lw $7 ; taken branch in EX while consumer of $7 waits in ID
    applyStimulus(1, 0, 0, 0, 0, 1, 7, 1, 0, 0);
    applyStimulus(1, 1, 7, 0, 0, 1, 8, 0, 1, 0);
    nop();
    check("stall_cnt_one", 32'(hz.stall_cnt), 32'd1);
    check("flush_cnt_one", 32'(hz.flush_cnt), 32'd1);

    // writes to $0 are never forwarded
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 1, 9, 0, 0, 0);
    nop();

    // en low in the middle of a load-use stall freezes everything
    applyStimulus(1, 0, 0, 0, 0, 1, 10, 1, 0, 0);
    applyStimulus(0, 1, 10, 0, 0, 1, 11, 0, 0, 0);
    applyStimulus(0, 1, 10, 0, 0, 1, 11, 0, 0, 0);
    applyStimulus(1, 1, 10, 0, 0, 1, 11, 0, 0, 0);
    applyStimulus(1, 1, 10, 0, 0, 1, 11, 0, 0, 0);
    nop();

    // syscall halt: two drain cycles, then halted; en low while halted
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    nop();
    nop();
    nop();
    check("halted_third", 32'(hz.halted), 32'd1);
    applyStimulus(0, 1, 1, 0, 0, 1, 1, 0, 0, 0);
    nop();
    resetDut();
    nop();
    check("cnt_cleared", 32'(hz.stall_cnt), 32'd0);

    // reset in the middle of the drain returns to RUN
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    nop();
    resetDut();
    nop();

    // random traffic over a small register window to provoke hazards
    for (int n = 0; n < RAND_CYCLES; n++) begin
      if (sinceHalt > DRAIN_CYC) haltedCycles++;
      if (haltedCycles >= 3) begin
        haltedCycles = 0;
        resetDut();
      end else begin
        applyStimulus(1'($urandom_range(0, 7) != 0),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                      1'($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, 7) == 0),
                      1'($urandom_range(0, 60) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
